// File: rtl/vram_console_pkg.sv
// Shared definitions for the VRAM text console.
//   - Default geometry of the tile index map (base address, columns, rows)
//   - Tile index used to blank the map
//   - Default VRAM read latency used by the scroll path
//   - Control-code constants understood by the console
//   - Console FSM state enumeration
// Optional feature: VRAM_CONSOLE_SCROLL_EN (see vram_console.sv).
package vram_console_pkg;

    localparam logic [15:0] C_index_base = 16'h4800;
    localparam int          C_cols       = 32;
    localparam int          C_rows       = 30;
    localparam logic [7:0]  C_fill       = 8'h20;
    localparam int          C_rd_lat     = 2;

    localparam logic [7:0]  C_chr_bs     = 8'h08;
    localparam logic [7:0]  C_chr_lf     = 8'h0A;
    localparam logic [7:0]  C_chr_ff     = 8'h0C;
    localparam logic [7:0]  C_chr_cr     = 8'h0D;

    typedef enum logic [2:0] {
        ST_CLEAR       = 3'd0,
        ST_IDLE        = 3'd1,
        ST_WRITE       = 3'd2,
        ST_CLEAR_ROW   = 3'd3,
        ST_SCROLL_RD   = 3'd4,
        ST_SCROLL_WAIT = 3'd5,
        ST_SCROLL_WR   = 3'd6
    } console_state_t;

    // Every byte that is not one of the four control codes is a tile index.
    function automatic logic is_control(input logic [7:0] b);
        return (b == C_chr_bs) || (b == C_chr_lf) ||
               (b == C_chr_ff) || (b == C_chr_cr);
    endfunction

endpackage

// File: rtl/vram_console_if.sv
// Byte-stream and VRAM-port bundle of the console.
//   I_char_valid / I_char_data / O_char_ready : byte handshake from the source
//   O_mem_addr / O_mem_data / O_mem_write     : VRAM write port (address also used for reads)
//   I_mem_data                                : VRAM read data (scroll only)
// modport master : the console itself
// modport slave  : the byte source plus the VRAM it shares
interface vram_console_if;
    logic        I_char_valid;
    logic [7:0]  I_char_data;
    logic        O_char_ready;
    logic [15:0] O_mem_addr;
    logic [7:0]  O_mem_data;
    logic        O_mem_write;
    logic [7:0]  I_mem_data;

    modport master (
        input  I_char_valid, I_char_data, I_mem_data,
        output O_char_ready, O_mem_addr, O_mem_data, O_mem_write
    );

    modport slave (
        output I_char_valid, I_char_data, I_mem_data,
        input  O_char_ready, O_mem_addr, O_mem_data, O_mem_write
    );
endinterface

// File: rtl/vram_console.sv
// Character-stream writer for the tile index map read by the tile scanout.
// Bytes arrive on a valid/ready handshake and become tile-index writes at a
// text cursor; BS, LF, CR and FF are interpreted, and the map is cleared,
// wrapped or scrolled as the cursor runs off its last row.
// Ports:
//   I_clock      system clock
//   I_reset      asynchronous reset, active low (restarts a full clear)
//   bus          vram_console_if.master: byte handshake + VRAM port
//   O_busy       high whenever the FSM is not idle
//   O_cursor_x   cursor column, O_cursor_y cursor row (post-update)
// Optional feature VRAM_CONSOLE_SCROLL_EN: when defined, a line feed on the
// last row scrolls the map up by one row (read/copy through the VRAM port)
// and blanks the last row; when undefined the cursor wraps to row 0 and
// only that row is blanked. P_rd_lat must be at least 1.
module vram_console
    import vram_console_pkg::*;
#(
    parameter logic [15:0] P_index_base = C_index_base,
    parameter int          P_cols       = C_cols,
    parameter int          P_rows       = C_rows,
    parameter logic [7:0]  P_fill       = C_fill,
    parameter int          P_rd_lat     = C_rd_lat
) (
    input  logic           I_clock,
    input  logic           I_reset,
    vram_console_if.master bus,
    output logic           O_busy,
    output logic [4:0]     O_cursor_x,
    output logic [4:0]     O_cursor_y
);

    localparam int         C_tiles = P_cols * P_rows;
    localparam int         CW      = $clog2(C_tiles) + 1;
    localparam logic [4:0] X_LAST  = 5'(P_cols - 1);
    localparam logic [4:0] Y_LAST  = 5'(P_rows - 1);

    console_state_t state_reg;
    logic [4:0]     cur_x_reg;
    logic [4:0]     cur_y_reg;
    logic [CW-1:0]  cnt_reg;
    logic [7:0]     char_reg;
    logic [15:0]    addr_reg;
    logic [7:0]     data_reg;
    logic           write_reg;
    logic           ready_reg;
    logic           lf_now;

`ifdef VRAM_CONSOLE_SCROLL_EN
    logic [3:0]     wait_reg;
`else
    logic           unused_mem_data;
    assign unused_mem_data = ^bus.I_mem_data;
`endif

    function automatic logic [15:0] tile_addr(input logic [4:0] y, input logic [4:0] x);
        return P_index_base + 16'(y) * 16'(P_cols) + 16'(x);
    endfunction

    // A line feed happens on an explicit LF or when a tile lands in the last column.
    always_comb begin
        lf_now = 1'b0;
        if (char_reg == C_chr_lf)
            lf_now = 1'b1;
        else if (!is_control(char_reg) && cur_x_reg == X_LAST)
            lf_now = 1'b1;
    end

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state_reg <= ST_CLEAR;
            cur_x_reg <= '0;
            cur_y_reg <= '0;
            cnt_reg   <= '0;
            char_reg  <= '0;
            addr_reg  <= P_index_base;
            data_reg  <= P_fill;
            write_reg <= 1'b0;
            ready_reg <= 1'b0;
`ifdef VRAM_CONSOLE_SCROLL_EN
            wait_reg  <= '0;
`endif
        end else begin
            write_reg <= 1'b0;
            case (state_reg)
                ST_CLEAR: begin
                    write_reg <= 1'b1;
                    addr_reg  <= P_index_base + 16'(cnt_reg);
                    data_reg  <= P_fill;
                    if (cnt_reg == CW'(C_tiles - 1)) begin
                        cnt_reg   <= '0;
                        ready_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                ST_IDLE: begin
                    if (bus.I_char_valid && ready_reg) begin
                        char_reg  <= bus.I_char_data;
                        ready_reg <= 1'b0;
                        state_reg <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    // Plain bytes return to IDLE; the branches below override this.
                    ready_reg <= 1'b1;
                    state_reg <= ST_IDLE;
                    case (char_reg)
                        C_chr_bs: begin
                            if (cur_x_reg != 5'd0) begin
                                cur_x_reg <= cur_x_reg - 5'd1;
                                write_reg <= 1'b1;
                                addr_reg  <= tile_addr(cur_y_reg, cur_x_reg - 5'd1);
                                data_reg  <= P_fill;
                            end
                        end
                        C_chr_cr, C_chr_lf: begin
                            cur_x_reg <= '0;
                        end
                        C_chr_ff: begin
                            cur_x_reg <= '0;
                            cur_y_reg <= '0;
                            cnt_reg   <= '0;
                            ready_reg <= 1'b0;
                            state_reg <= ST_CLEAR;
                        end
                        default: begin
                            write_reg <= 1'b1;
                            addr_reg  <= tile_addr(cur_y_reg, cur_x_reg);
                            data_reg  <= char_reg;
                            cur_x_reg <= (cur_x_reg == X_LAST) ? 5'd0 : cur_x_reg + 5'd1;
                        end
                    endcase
                    if (lf_now) begin
                        if (cur_y_reg != Y_LAST) begin
                            cur_y_reg <= cur_y_reg + 5'd1;
                        end else begin
                            ready_reg <= 1'b0;
`ifdef VRAM_CONSOLE_SCROLL_EN
                            // Copy tiles P_cols..end one row up, then blank the last row.
                            cnt_reg   <= CW'(P_cols);
                            state_reg <= ST_SCROLL_RD;
`else
                            cnt_reg   <= '0;
                            cur_y_reg <= '0;
                            state_reg <= ST_CLEAR_ROW;
`endif
                        end
                    end
                end

                ST_CLEAR_ROW: begin
                    write_reg <= 1'b1;
                    addr_reg  <= tile_addr(cur_y_reg, 5'(cnt_reg));
                    data_reg  <= P_fill;
                    if (cnt_reg == CW'(P_cols - 1)) begin
                        cnt_reg   <= '0;
                        ready_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

`ifdef VRAM_CONSOLE_SCROLL_EN
                ST_SCROLL_RD: begin
                    addr_reg  <= P_index_base + 16'(cnt_reg);
                    wait_reg  <= '0;
                    state_reg <= ST_SCROLL_WAIT;
                end

                // Address is held here; read data is sampled P_rd_lat edges after it appeared.
                ST_SCROLL_WAIT: begin
                    if (wait_reg == 4'(P_rd_lat - 1)) begin
                        data_reg  <= bus.I_mem_data;
                        state_reg <= ST_SCROLL_WR;
                    end else begin
                        wait_reg <= wait_reg + 4'd1;
                    end
                end

                ST_SCROLL_WR: begin
                    write_reg <= 1'b1;
                    addr_reg  <= P_index_base + 16'(cnt_reg) - 16'(P_cols);
                    if (cnt_reg == CW'(C_tiles - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_CLEAR_ROW;
                    end else begin
                        cnt_reg   <= cnt_reg + 1'b1;
                        state_reg <= ST_SCROLL_RD;
                    end
                end
`endif

                default: begin
                    cnt_reg   <= '0;
                    ready_reg <= 1'b0;
                    state_reg <= ST_CLEAR;
                end
            endcase
        end
    end

    assign bus.O_char_ready = ready_reg;
    assign bus.O_mem_addr   = addr_reg;
    assign bus.O_mem_data   = data_reg;
    assign bus.O_mem_write  = write_reg;
    assign O_busy           = (state_reg != ST_IDLE);
    assign O_cursor_x       = cur_x_reg;
    assign O_cursor_y       = cur_y_reg;

endmodule

// File: tb/tb_vram_console.sv
// Self-checking bench for vram_console: reset/clear, a table of single-byte
// vectors, line-wrap, last-row line feed (wrap or scroll depending on
// VRAM_CONSOLE_SCROLL_EN), reset during a multi-cycle operation, and random
// byte streams compared with a screen-level reference model.
module tb_vram_console;
    import vram_console_pkg::*;

    localparam logic [15:0] BASE  = 16'h4800;
    localparam int          COLS  = 32;
    localparam int          ROWS  = 30;
    localparam int          TILES = COLS * ROWS;
    localparam logic [7:0]  FILL  = 8'h20;
    localparam int          LAT   = 2;
`ifdef VRAM_CONSOLE_SCROLL_EN
    localparam bit SCROLL = 1'b1;
`else
    localparam bit SCROLL = 1'b0;
`endif

    logic       I_clock = 1'b0;
    logic       I_reset = 1'b0;
    logic       O_busy;
    logic [4:0] O_cursor_x;
    logic [4:0] O_cursor_y;

    vram_console_if bus();

    vram_console #(
        .P_index_base(BASE), .P_cols(COLS), .P_rows(ROWS),
        .P_fill(FILL), .P_rd_lat(LAT)
    ) dut (
        .I_clock   (I_clock),
        .I_reset   (I_reset),
        .bus       (bus.master),
        .O_busy    (O_busy),
        .O_cursor_x(O_cursor_x),
        .O_cursor_y(O_cursor_y)
    );

    always #5 I_clock = ~I_clock;

    // VRAM with a two-cycle read: address seen at edge e, data sampled at edge e+2.
    logic [7:0] vram [0:65535];
    logic [7:0] rd_q;
    always @(posedge I_clock) begin
        if (bus.O_mem_write) vram[bus.O_mem_addr] <= bus.O_mem_data;
        rd_q <= vram[bus.O_mem_addr];
    end
    assign bus.I_mem_data = rd_q;

    typedef struct { logic [15:0] addr; logic [7:0] data; } wr_t;
    wr_t obs_q[$];
    wr_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model: a flat screen array + cursor ----------------
    logic [7:0] m_scr [0:TILES-1];
    int m_x, m_y;

    function automatic void m_put(input int idx, input logic [7:0] v);
        m_scr[idx] = v;
        exp_q.push_back('{addr: BASE + 16'(idx), data: v});
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < TILES; i++) m_put(i, FILL);
        m_x = 0;
        m_y = 0;
    endfunction

    function automatic void model_lf();
        if (m_y < ROWS - 1) begin
            m_y++;
        end else if (SCROLL) begin
            for (int i = COLS; i < TILES; i++) m_put(i - COLS, m_scr[i]);
            for (int c = 0; c < COLS; c++) m_put((ROWS - 1) * COLS + c, FILL);
        end else begin
            m_y = 0;
            for (int c = 0; c < COLS; c++) m_put(c, FILL);
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        case (b)
            8'h08: if (m_x > 0) begin m_x--; m_put(m_y * COLS + m_x, FILL); end
            8'h0A: begin m_x = 0; model_lf(); end
            8'h0D: m_x = 0;
            8'h0C: model_clear();
            default: begin
                m_put(m_y * COLS + m_x, b);
                if (m_x == COLS - 1) begin m_x = 0; model_lf(); end
                else m_x++;
            end
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic compare_writes(input string name);
        int bad;
        chk({name, "_nwrites"}, obs_q.size(), exp_q.size());
        bad = -1;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (bad < 0 && (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data))
                bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s_seq at write %0d actual=%h:%h required=%h:%h", name, bad,
                     obs_q[bad].addr, obs_q[bad].data, exp_q[bad].addr, exp_q[bad].data);
        end
        exp_q.delete();
    endtask

    // Collect writes at negedges until idle with ready; counts ready-low cycles.
    task automatic run_until_idle(input int budget, output int low);
        int n;
        low = 0;
        n   = 0;
        forever begin
            @(negedge I_clock);
            if (!bus.O_char_ready) low++;
            if (bus.O_mem_write) obs_q.push_back('{addr: bus.O_mem_addr, data: bus.O_mem_data});
            if (!O_busy && bus.O_char_ready) break;
            n++;
            if (n >= budget) begin
                checks++;
                failures++;
                $display("FAIL idle_timeout actual=busy required=idle_within_%0d", budget);
                break;
            end
        end
    endtask

    task automatic send(input logic [7:0] b, output int low);
        obs_q.delete();
        chk("ready_before_send", bus.O_char_ready, 1'b1);
        bus.I_char_valid = 1'b1;
        bus.I_char_data  = b;
        @(posedge I_clock);
        #1 bus.I_char_valid = 1'b0;
        run_until_idle(5000, low);
    endtask

    task automatic apply(input logic [7:0] b, input string name);
        int low;
        model_byte(b);
        send(b, low);
        $display("tx %s byte=%h writes=%0d cursor=(%0d,%0d)", name, b, obs_q.size(), O_cursor_x, O_cursor_y);
        compare_writes(name);
        chk({name, "_cx"}, O_cursor_x, m_x);
        chk({name, "_cy"}, O_cursor_y, m_y);
    endtask

    task automatic do_reset(input bit check_vals);
        int low;
        #2 I_reset = 1'b0;
        repeat (3) @(negedge I_clock);
        if (check_vals) begin
            chk("rst_ready", bus.O_char_ready, 1'b0);
            chk("rst_write", bus.O_mem_write, 1'b0);
            chk("rst_addr",  bus.O_mem_addr, 16'h4800);
            chk("rst_data",  bus.O_mem_data, 8'h20);
            chk("rst_busy",  O_busy, 1'b1);
            chk("rst_cx",    O_cursor_x, 0);
            chk("rst_cy",    O_cursor_y, 0);
        end
        I_reset = 1'b1;
        exp_q.delete();
        obs_q.delete();
        model_clear();
        run_until_idle(2000, low);
        $display("tx reset_clear writes=%0d first=%h last=%h", obs_q.size(),
                 (obs_q.size() > 0) ? obs_q[0].addr : 16'h0,
                 (obs_q.size() > 0) ? obs_q[obs_q.size()-1].addr : 16'h0);
        compare_writes("reset_clear");
        chk("clear_cx", O_cursor_x, 0);
        chk("clear_cy", O_cursor_y, 0);
        chk("clear_ready", bus.O_char_ready, 1'b1);
    endtask

    typedef struct {
        logic [7:0]  ch;
        int          ex, ey, nwr;
        logic [15:0] la;
        logic [7:0]  ld;
        int          low;
    } vec_t;
    vec_t tbl [8];

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        int bad;
        logic [7:0] b;
        int r;

        bus.I_char_valid = 1'b0;
        bus.I_char_data  = 8'h00;

        tbl[0] = '{8'h41, 1, 0, 1, 16'h4800, 8'h41, 1};
        tbl[1] = '{8'h08, 0, 0, 1, 16'h4800, 8'h20, 1};
        tbl[2] = '{8'h08, 0, 0, 0, 16'h0000, 8'h00, 1};
        tbl[3] = '{8'h42, 1, 0, 1, 16'h4800, 8'h42, 1};
        tbl[4] = '{8'h0D, 0, 0, 0, 16'h0000, 8'h00, 1};
        tbl[5] = '{8'h0A, 0, 1, 0, 16'h0000, 8'h00, 1};
        tbl[6] = '{8'h43, 1, 1, 1, 16'h4820, 8'h43, 1};
        tbl[7] = '{8'h0C, 0, 0, 960, 16'h4BBF, 8'h20, -1};

        @(negedge I_clock);
        do_reset(1'b1);

        // Table-driven single-byte vectors.
        for (int i = 0; i < 8; i++) begin
            model_byte(tbl[i].ch);
            send(tbl[i].ch, low);
            $display("tx vec%0d byte=%h writes=%0d cursor=(%0d,%0d) ready_low=%0d", i, tbl[i].ch,
                     obs_q.size(), O_cursor_x, O_cursor_y, low);
            compare_writes("vec_model");
            chk("vec_cx", O_cursor_x, tbl[i].ex);
            chk("vec_cy", O_cursor_y, tbl[i].ey);
            chk("vec_nwr", obs_q.size(), tbl[i].nwr);
            if (tbl[i].nwr > 0 && obs_q.size() > 0) begin
                chk("vec_last_addr", obs_q[obs_q.size()-1].addr, tbl[i].la);
                chk("vec_last_data", obs_q[obs_q.size()-1].data, tbl[i].ld);
            end
            if (tbl[i].low >= 0) chk("vec_ready_low", low, tbl[i].low);
        end

        // 33 tiles from (0,0): the 33rd lands at the start of row 1.
        for (int i = 0; i < 33; i++) apply(8'h42, "wrap33");
        chk("wrap33_addr", (obs_q.size() > 0) ? obs_q[0].addr : 16'h0, 16'h4820);
        chk("wrap33_cx", O_cursor_x, 1);
        chk("wrap33_cy", O_cursor_y, 1);

        // Line feed on the last row, with 0x55 planted at 0x4820.
        apply(8'h0C, "ff");
        apply(8'h0A, "lf");
        apply(8'h55, "plant");
        for (int i = 0; i < 28; i++) apply(8'h0A, "lf");
        for (int i = 0; i < 5; i++) apply(8'h58, "row29");
        chk("pre_lf_cx", O_cursor_x, 5);
        chk("pre_lf_cy", O_cursor_y, 29);
        apply(8'h0A, "last_lf");
        @(posedge I_clock);
        @(negedge I_clock);
        if (SCROLL) begin
            chk("scroll_top", vram[16'h4800], 8'h55);
            bad = 0;
            for (int a = 16'h4BA0; a <= 16'h4BBF; a++) if (vram[a] !== 8'h20) bad++;
            chk("scroll_lastrow_bad", bad, 0);
            chk("scroll_cx", O_cursor_x, 0);
            chk("scroll_cy", O_cursor_y, 29);
        end else begin
            chk("wrap_nwr", obs_q.size(), 32);
            chk("wrap_first", (obs_q.size() > 0) ? obs_q[0].addr : 16'h0, 16'h4800);
            chk("wrap_last", (obs_q.size() > 31) ? obs_q[31].addr : 16'h0, 16'h481F);
            chk("wrap_cx", O_cursor_x, 0);
            chk("wrap_cy", O_cursor_y, 0);
        end

        // Reset while a last-row line feed is still in progress.
        while (m_y < ROWS - 1) apply(8'h0A, "to_last");
        bus.I_char_valid = 1'b1;
        bus.I_char_data  = 8'h0A;
        @(posedge I_clock);
        #1 bus.I_char_valid = 1'b0;
        repeat (12) @(negedge I_clock);
        chk("busy_mid_op", O_busy, 1'b1);
        do_reset(1'b0);

        // Random byte stream against the model.
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 99);
            if (r < 5)        b = 8'h0A;
            else if (r < 8)   b = 8'h0D;
            else if (r < 13)  b = 8'h08;
            else if (r == 13) b = 8'h0C;
            else begin
                b = 8'($urandom_range(0, 255));
                if (is_control(b)) b = 8'h2A;
            end
            apply(b, "rand");
        end

        @(posedge I_clock);
        @(negedge I_clock);
        bad = 0;
        for (int i = 0; i < TILES; i++) if (vram[BASE + 16'(i)] !== m_scr[i]) bad++;
        chk("final_screen_bad", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
